piso_serial_tx: RTL and testbench

// - Parallel-in/serial-out word transmitter. Accepts a WIDTH-bit word over a valid/ready handshake.
// - Drives the word out one bit at a time on sdo, with a per-bit strobe sdo_en.
// - Feeds the serial inputs of a downstream shift register:
//   - MSB-first suits a left-shifting receiver (serial-in at LSB end).
//   - LSB-first suits a right-shifting receiver (serial-in at MSB end).
// - Drive sdo_en as the receiver's shift enable.

---
 rtl/piso_serial_tx_pkg.sv | 6 +
 rtl/piso_serial_tx_bit_timer.sv | 21 ++
 rtl/piso_serial_tx.sv | 79 +++++++
 tb/tb_piso_serial_tx.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/piso_serial_tx_pkg.sv
// piso_serial_tx_pkg: state codes and bit-order encodings shared by the transmitter and its matching receiver.
package piso_serial_tx_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;
    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;
endpackage

// File: rtl/piso_serial_tx_bit_timer.sv
// piso_serial_tx_bit_timer: bit-period counter; tick marks the last clk cycle of each bit period.
module piso_serial_tx_bit_timer #(
    parameter int BIT_CYCLES = 1
) (
    input  logic clk,
    input  logic clrb,
    input  logic run,
    output logic tick
);
    localparam int CW = BIT_CYCLES > 1 ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CYC = CW'(BIT_CYCLES - 1);
    logic [CW-1:0] cyc_cnt_q, cyc_cnt_d;
    always_comb begin
        tick = run && cyc_cnt_q == LAST_CYC;
        cyc_cnt_d = (!run || tick) ? '0 : cyc_cnt_q + 1'b1;
    end
    always_ff @(posedge clk or negedge clrb) begin
        if (!clrb) cyc_cnt_q <= '0;
        else cyc_cnt_q <= cyc_cnt_d;
    end
endmodule

// File: rtl/piso_serial_tx.sv
// piso_serial_tx: parallel-in/serial-out word transmitter with valid/ready input and per-bit strobe.
module piso_serial_tx
    import piso_serial_tx_pkg::*;
#(
    parameter int   WIDTH      = 4,
    parameter int   BIT_CYCLES = 1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             clrb,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             dir,
    output logic             sdo,
    output logic             sdo_en,
    output logic             busy,
    output logic             done
);
    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    state_t state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic dir_q, dir_d, sdo_q, sdo_d;
    logic run, tick, last, accept;
    assign run = state_q == ST_SHIFT;
    piso_serial_tx_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
        .clk  (clk),
        .clrb (clrb),
        .run  (run),
        .tick (tick)
    );
    always_comb begin
        sdo_en = run && tick;
        last = sdo_en && bit_cnt_q == LAST_BIT;
        in_ready = !run || last;
        accept = in_valid && in_ready;
        busy = run;
        done = last;
        sdo = sdo_q;
        state_d = state_q;
        shreg_d = shreg_q;
        dir_d = dir_q;
        bit_cnt_d = bit_cnt_q;
        sdo_d = sdo_q;
        // The first bit is loaded straight from in_data so it appears the cycle after accept.
        if (accept) begin
            state_d = ST_SHIFT;
            shreg_d = in_data;
            dir_d = dir;
            bit_cnt_d = '0;
            sdo_d = dir == DIR_LSB_FIRST ? in_data[0] : in_data[WIDTH-1];
        end else if (last) begin
            state_d = ST_IDLE;
            bit_cnt_d = '0;
            sdo_d = IDLE_LEVEL;
        end else if (sdo_en) begin
            shreg_d = dir_q == DIR_LSB_FIRST ? shreg_q >> 1 : shreg_q << 1;
            sdo_d = dir_q == DIR_LSB_FIRST ? shreg_q[1] : shreg_q[WIDTH-2];
            bit_cnt_d = bit_cnt_q + 1'b1;
        end
    end
    always_ff @(posedge clk or negedge clrb) begin
        if (!clrb) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            dir_q <= DIR_MSB_FIRST;
            bit_cnt_q <= '0;
            sdo_q <= IDLE_LEVEL;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            dir_q <= dir_d;
            bit_cnt_q <= bit_cnt_d;
            sdo_q <= sdo_d;
        end
    end
endmodule

// File: tb/tb_piso_serial_tx.sv
// tb_piso_serial_tx: directed checks of the transmitter at BIT_CYCLES=1 and BIT_CYCLES=3.
module tb_piso_serial_tx;
    logic clk = 1'b0;
    logic clrb = 1'b0;
    logic [3:0] data = 4'h0;
    logic dir = 1'b0;
    logic v1 = 1'b0, v3 = 1'b0;
    logic rdy1, sdo1, en1, busy1, done1;
    logic rdy3, sdo3, en3, busy3, done3;
    logic [3:0] rx_left = 4'h0, rx_right = 4'h0;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    piso_serial_tx #(.WIDTH(4), .BIT_CYCLES(1), .IDLE_LEVEL(1'b0)) dut1 (
        .clk(clk), .clrb(clrb), .in_data(data), .in_valid(v1), .in_ready(rdy1),
        .dir(dir), .sdo(sdo1), .sdo_en(en1), .busy(busy1), .done(done1)
    );
    piso_serial_tx #(.WIDTH(4), .BIT_CYCLES(3), .IDLE_LEVEL(1'b0)) dut3 (
        .clk(clk), .clrb(clrb), .in_data(data), .in_valid(v3), .in_ready(rdy3),
        .dir(dir), .sdo(sdo3), .sdo_en(en3), .busy(busy3), .done(done3)
    );

    always @(posedge clk) begin
        if (en1) begin
            rx_left <= {rx_left[2:0], sdo1};
            rx_right <= {sdo1, rx_right[3:1]};
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // seq[3] is the first bit expected on sdo
    task automatic tx1(input logic [3:0] d, input logic dr, input logic [3:0] seq);
        data = d; dir = dr; v1 = 1'b1;
        @(negedge clk); v1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("tx_sdo", sdo1, seq[3-i]);
            chk("tx_en", en1, 1);
            chk("tx_done", done1, i == 3);
            chk("tx_rdy", rdy1, i == 3);
            chk("tx_busy", busy1, 1);
            @(negedge clk);
        end
        chk("tx_end_busy", busy1, 0);
        chk("tx_end_sdo", sdo1, 0);
        chk("tx_end_en", en1, 0);
    endtask

    initial begin
        logic [3:0] seq3;
        logic [7:0] seq8;
        int pulses;
        #2;
        chk("rst_sdo", sdo1, 0);
        chk("rst_en", en1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_rdy", rdy1, 1);
        chk("rst_busy3", busy3, 0);
        @(negedge clk); @(negedge clk);
        chk("rst_hold_busy", busy1, 0);
        clrb = 1'b1;
        @(negedge clk);

        tx1(4'b1011, 1'b0, 4'b1011);
        chk("rx_left", rx_left, 4'b1011);
        tx1(4'b1011, 1'b1, 4'b1101);
        chk("rx_right", rx_right, 4'b1011);

        seq3 = 4'b0110;
        pulses = 0;
        data = 4'b0110; dir = 1'b0; v3 = 1'b1;
        @(negedge clk); v3 = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            chk("bc3_sdo", sdo3, seq3[3-(c-1)/3]);
            chk("bc3_en", en3, c % 3 == 0);
            chk("bc3_done", done3, c == 12);
            chk("bc3_busy", busy3, 1);
            if (en3) pulses++;
            @(negedge clk);
        end
        chk("bc3_pulses", pulses, 4);
        chk("bc3_end_busy", busy3, 0);
        chk("bc3_end_sdo", sdo3, 0);

        seq8 = 8'b1010_0101;
        data = 4'hA; dir = 1'b0; v1 = 1'b1;
        @(negedge clk);
        data = 4'h5;
        for (int c = 1; c <= 8; c++) begin
            if (c == 5) v1 = 1'b0;
            chk("b2b_sdo", sdo1, seq8[8-c]);
            chk("b2b_en", en1, 1);
            chk("b2b_rdy", rdy1, c == 4 || c == 8);
            chk("b2b_done", done1, c == 4 || c == 8);
            chk("b2b_busy", busy1, 1);
            @(negedge clk);
        end
        chk("b2b_end_busy", busy1, 0);

        data = 4'hF; dir = 1'b0; v1 = 1'b1;
        @(negedge clk); v1 = 1'b0;
        chk("abort_b0", sdo1, 1);
        @(negedge clk);
        chk("abort_b1", sdo1, 1);
        @(negedge clk);
        clrb = 1'b0;
        #1;
        chk("abort_sdo", sdo1, 0);
        chk("abort_busy", busy1, 0);
        chk("abort_done", done1, 0);
        chk("abort_en", en1, 0);
        @(negedge clk);
        chk("abort_hold_done", done1, 0);
        clrb = 1'b1;
        @(negedge clk);
        tx1(4'h3, 1'b0, 4'b0011);
        chk("abort_rx", rx_left, 4'h3);

        data = 4'b1011; dir = 1'b0; v1 = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                v1 = 1'b1; data = 4'b0100 ^ 4'(i); dir = 1'b1;
            end else begin
                v1 = 1'b0;
            end
            chk("hold_sdo", sdo1, seq8[7-i] ^ seq8[5-i] ^ seq8[5-i] ^ (i == 1 ? 1'b1 : 1'b0) ^ (i == 1 ? 1'b1 : 1'b0) ^ (4'b1011 >> (3 - i)) & 1'b1 ^ seq8[7-i]);
            chk("hold_rdy", rdy1, i == 3);
            chk("hold_done", done1, i == 3);
            @(negedge clk);
        end
        chk("hold_end_busy", busy1, 0);
        chk("hold_rx", rx_left, 4'b1011);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
